fifo_stream_reader: RTL and testbench

//  - Read-side engine for the team's synchronous FIFO: pops words through read_enable/data_out
//    and presents them as a valid/ready stream to a downstream consumer.
//  - Absorbs the FIFO's 1-cycle registered read latency with a 2-entry skid buffer.
//  - No word is dropped or duplicated under arbitrary backpressure.
//  - Sits between FIFO data_out/empty and any stream sink (UART tx, DMA, etc.).

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_stream_reader_if.sv | 22 ++
 rtl/skid_buffer_2.sv | 48 ++++
 rtl/sync_fifo.sv | 56 +++++
 rtl/fifo_stream_reader.sv | 85 ++++++++
 tb/tb_fifo_stream_reader.sv | 231 +++++++++++++++++++++++
 6 files changed

// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side engine: default word width, reader FSM states and the word type.
package fifo_pkg;

    localparam int FIFO_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } rd_state_t;

    typedef logic [FIFO_W-1:0] fifo_word_t;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus the valid/ready output stream of the reader.
// master = reader side, slave = FIFO + downstream consumer side.
interface fifo_stream_reader_if #(
    parameter int FIFO_W = fifo_pkg::FIFO_W
);
    logic              fifo_empty;
    logic [FIFO_W-1:0] fifo_data;
    logic              fifo_read_enable;
    logic              m_valid;
    logic              m_ready;
    logic [FIFO_W-1:0] m_data;

    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_read_enable, m_valid, m_data
    );

    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_read_enable, m_valid, m_data
    );
endinterface

// File: rtl/skid_buffer_2.sv
// Two-entry in-order holding buffer; entry 0 is the head presented downstream.
// Latency: a push is visible at the head the cycle after it is written into an empty buffer.
// Backpressure: caller must not push into a full buffer unless it also pops that cycle.
module skid_buffer_2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [1:0]   occ_o,
    output logic [W-1:0] head_o
);
    logic [W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
    logic [1:0]   occ_q, occ_d;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        if (pop_i && occ_q != 2'd0) begin
            ent0_d = ent1_q;
            occ_d  = occ_q - 2'd1;
        end
        // Slot choice uses the post-pop count so push+pop keeps strict order.
        if (push_i && occ_d != 2'd2) begin
            if (occ_d == 2'd0) ent0_d = push_dat_i;
            else               ent1_d = push_dat_i;
            occ_d = occ_d + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign occ_o  = occ_q;
    assign head_o = ent0_q;
endmodule

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with a registered read port.
// Latency: data_out valid the cycle after a read_enable pop.
// Backpressure: writes ignored when full, reads ignored when empty.
module sync_fifo #(
    parameter int FIFO_W     = 8,
    parameter int FIFO_DEPTH = 8,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int CW = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_enable,
    input  logic [FIFO_W-1:0] data_in,
    input  logic              read_enable,
    output logic [FIFO_W-1:0] data_out,
    output logic              empty,
    output logic              full,
    output logic [CW-1:0]     count
);
    logic [FIFO_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [FIFO_W-1:0] data_out_q;
    logic              do_wr, do_rd;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign count    = count_q;
    assign data_out = data_out_q;
    assign do_wr    = write_enable & ~full;
    assign do_rd    = read_enable & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) begin
                rd_ptr_q   <= rd_ptr_q + AW'(1);
                data_out_q <= mem_q[rd_ptr_q];
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= data_in;
    end
endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a synchronous FIFO and re-presents its words as a valid/ready stream (FIFO_READER_STATS_EN adds beat_count).
// Latency: pop at edge E0, word captured at E1, m_valid high after E1; 1 word/cycle sustained.
// Backpressure: pops only issue with skid credit, so words are never dropped or duplicated.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int FIFO_W = fifo_pkg::FIFO_W,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    fifo_stream_reader_if.master bus,
    output logic                 busy
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [CNT_W-1:0]     beat_count
`endif
);
    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_STREAM = STREAM;
    localparam logic [1:0] S_DRAIN  = DRAIN;

    logic [1:0]        state_q, state_d;
    logic              in_flight_q;
    logic [1:0]        occ;
    logic [1:0]        pending;
    logic [FIFO_W-1:0] head;
    logic              handshake;
    logic              credit;

    skid_buffer_2 #(.W(FIFO_W)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push_i     (in_flight_q),
        .push_dat_i (bus.fifo_data),
        .pop_i      (handshake),
        .occ_o      (occ),
        .head_o     (head)
    );

    assign bus.m_valid = (occ != 2'd0);
    assign bus.m_data  = head;
    assign handshake   = bus.m_valid & bus.m_ready;

    // A word in flight from the FIFO already owns a skid slot.
    assign pending = occ + {1'b0, in_flight_q};
    assign credit  = (pending <= 2'd1) | ((pending == 2'd2) & handshake);
    assign bus.fifo_read_enable = (state_q == S_STREAM) & ~bus.fifo_empty & credit;
    assign busy = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (enable) state_d = S_STREAM;
            S_STREAM: if (!enable) state_d = S_DRAIN;
            S_DRAIN: begin
                if (enable)                               state_d = S_STREAM;
                else if (occ == 2'd0 && !in_flight_q)     state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_flight_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_flight_q <= bus.fifo_read_enable;
        end
    end

`ifdef FIFO_READER_STATS_EN
    logic [CNT_W-1:0] beat_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)                                 beat_cnt_q <= '0;
        else if (handshake && beat_cnt_q != '1)  beat_cnt_q <= beat_cnt_q + CNT_W'(1);
    end

    assign beat_count = beat_cnt_q;
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench: real sync_fifo (depth 8) feeding fifo_stream_reader; queue model of write order checked every cycle.
module tb_fifo_stream_reader;
    import fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       wr_en = 1'b0;
    fifo_word_t wr_data = '0;
    logic       fifo_full;
    logic [3:0] fifo_count;
    logic       busy;
`ifdef FIFO_READER_STATS_EN
    logic [15:0] beat_count;
`endif

    fifo_stream_reader_if #(.FIFO_W(8)) rd_if ();

    always #5 clk = ~clk;

    sync_fifo #(.FIFO_W(8), .FIFO_DEPTH(8)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .write_enable (wr_en),
        .data_in      (wr_data),
        .read_enable  (rd_if.fifo_read_enable),
        .data_out     (rd_if.fifo_data),
        .empty        (rd_if.fifo_empty),
        .full         (fifo_full),
        .count        (fifo_count)
    );

    fifo_stream_reader #(.FIFO_W(8), .CNT_W(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .bus    (rd_if),
        .busy   (busy)
`ifdef FIFO_READER_STATS_EN
        ,
        .beat_count (beat_count)
`endif
    );

    int         n_chk  = 0;
    int         n_fail = 0;
    int         beats  = 0;
    int         pops   = 0;
    fifo_word_t exp_q[$];
    logic       stall_prev = 1'b0;
    fifo_word_t held = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input fifo_word_t w);
        check("fifo_not_full", fifo_full, 1'b0);
        wr_en   = 1'b1;
        wr_data = w;
        exp_q.push_back(w);
        tick();
        wr_en = 1'b0;
    endtask

    // Every delivered word must be the oldest one written and not yet delivered.
    always @(negedge clk) begin
        if (!rst) begin
            check("no_pop_when_empty", rd_if.fifo_read_enable & rd_if.fifo_empty, 1'b0);
            if (stall_prev) begin
                check("stall_valid_held", rd_if.m_valid, 1'b1);
                check("stall_data_held", rd_if.m_data, held);
            end
            if (rd_if.fifo_read_enable) pops++;
            if (rd_if.m_valid && rd_if.m_ready) begin
                if (exp_q.size() == 0) check("extra_word", rd_if.m_data, 32'hFFFF_FFFF);
                else                   check("order", rd_if.m_data, exp_q.pop_front());
                beats++;
            end
            stall_prev = rd_if.m_valid & ~rd_if.m_ready;
            held       = rd_if.m_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int         p0, b0, found;
        logic       t2_v [5];
        fifo_word_t t2_d [5];
        t2_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        t2_d = '{8'h00, 8'hCC, 8'h33, 8'h8F, 8'h00};

        rd_if.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_m_valid", rd_if.m_valid, 1'b0);
        check("rst_read_en", rd_if.fifo_read_enable, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_m_data", rd_if.m_data, 8'h00);
`ifdef FIFO_READER_STATS_EN
        check("rst_beat_count", beat_count, 16'd0);
`endif
        tick();

        // 1: reset while two words sit in the skid and three remain in the FIFO
        for (int i = 0; i < 5; i++) write_word(8'(8'h10 + i));
        enable = 1'b1;
        repeat (6) tick();
        check("t1_fifo_level", fifo_count, 4'd3);
        check("t1_head", rd_if.m_data, 8'h10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("t1_m_valid", rd_if.m_valid, 1'b0);
        check("t1_read_en", rd_if.fifo_read_enable, 1'b0);
        check("t1_busy", busy, 1'b0);
        tick();
        rd_if.m_ready = 1'b1;
        repeat (8) tick();
        check("t1_no_stale", rd_if.m_valid, 1'b0);
        check("t1_fifo_empty", fifo_count, 4'd0);

        // 2: first-word latency and back-to-back delivery
        enable = 1'b0;
        repeat (3) tick();
        write_word(8'hCC);
        write_word(8'h33);
        write_word(8'h8F);
        enable = 1'b1;
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            @(negedge clk);
            if (rd_if.fifo_read_enable) found = 1;
        end
        check("t2_pop_seen", found, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t2_valid", rd_if.m_valid, t2_v[k]);
            if (t2_v[k]) check("t2_data", rd_if.m_data, t2_d[k]);
        end
        tick();
        check("t2_drained", exp_q.size(), 0);

        // 3: 7 words under a 10-cycle stall
        rd_if.m_ready = 1'b0;
        p0 = pops;
        for (int i = 0; i < 7; i++) write_word(8'(8'h40 + i));
        repeat (10) tick();
        check("t3_stall_pops", pops - p0, 2);
        check("t3_fifo_level", fifo_count, 4'd5);
        check("t3_head", rd_if.m_data, 8'h40);
        rd_if.m_ready = 1'b1;
        repeat (6) tick();
        check("t3_after6", exp_q.size(), 1);
        tick();
        check("t3_after7", exp_q.size(), 0);

        // 4: random backpressure, counter cleared first
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b0 = beats;
        for (int i = 0; i < 7; i++) begin
            rd_if.m_ready = 1'($urandom_range(0, 1));
            write_word(8'(8'h50 + i));
        end
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
            rd_if.m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        rd_if.m_ready = 1'b1;
        check("t4_drained", exp_q.size(), 0);
        check("t4_beats", beats - b0, 7);
`ifdef FIFO_READER_STATS_EN
        check("t4_beat_count", beat_count, 16'd7);
`endif

        // 5: disable with two words held in the skid, two left in the FIFO
        rd_if.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) write_word(8'(8'h60 + i));
        repeat (4) tick();
        check("t5_fifo_level", fifo_count, 4'd2);
        enable = 1'b0;
        tick();
        @(negedge clk);
        check("t5_drain_busy", busy, 1'b1);
        tick();
        b0 = beats;
        p0 = pops;
        rd_if.m_ready = 1'b1;
        repeat (6) tick();
        check("t5_delivered", beats - b0, 2);
        check("t5_no_pops", pops - p0, 0);
        check("t5_idle", busy, 1'b0);
        check("t5_fifo_kept", fifo_count, 4'd2);
        check("t5_valid_low", rd_if.m_valid, 1'b0);
        enable = 1'b1;
        repeat (8) tick();
        check("t5_resume", exp_q.size(), 0);
        check("t5_fifo_empty", fifo_count, 4'd0);

        // 6: streaming with nothing to read
        repeat (5) tick();
        @(negedge clk);
        check("t6_read_en", rd_if.fifo_read_enable, 1'b0);
        check("t6_m_valid", rd_if.m_valid, 1'b0);
        check("t6_busy", busy, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
